// File: rtl/pipe_seg_reg.sv
// pipe_seg_reg -- generic pipeline segment register.
//
// Carries an opaque data bundle and a control bundle from one pipeline stage
// to the next. It is used for every inter-stage boundary (IF/ID, ID/EX,
// EX/Mem, Mem/WB); each stage instantiates it with its own concatenated
// field widths. All state changes on the falling edge of clk.
//
// Parameters
//   DATA_W : width of the data bundle (passed bit-exact)
//   CTRL_W : width of the control bundle (forced to zero for a bubble)
//   SKID   : 1 = two-entry skid buffer, registered in_ready
//            0 = single register, combinational in_ready
//   CNT_W  : width of the saturating stall counter
//
// Ports
//   clk       : clock, state updates on falling edge
//   rst       : synchronous active-high reset
//   flush     : squash every held entry (and any entry offered this cycle)
//   in_valid  : upstream offers an entry
//   in_ready  : segment accepts an entry this cycle
//   in_ctrl   : upstream control bundle
//   in_data   : upstream data bundle
//   out_valid : head entry is valid
//   out_ready : downstream consumes the head entry this cycle
//   out_ctrl  : head control bundle, zero when out_valid=0
//   out_data  : head data bundle, last held value when out_valid=0
//   stall_cnt : saturating count of edges with out_valid=1 and out_ready=0
//
// Handshake: an entry moves on a falling edge where valid and ready are both
// high on that side (in_fire / out_fire). valid, once raised, is held with
// stable payload by the producer until the transfer happens; ready may change
// freely and never waits on valid.

module pipe_seg_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Main entry M: drives the outputs.
  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;

  // Skid entry S: only meaningful when SKID=1.
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;
  logic stall;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_q & out_ready;
  assign stall    = m_valid_q & ~out_ready;

  assign out_valid = m_valid_q;
  // A bubble must never present live control bits (RegWr, MemWr, ...)
  // downstream, whatever stale value M still holds.
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign out_data  = m_data_q;
  assign stall_cnt = cnt_q;

  // Saturating stall counter: sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  if (SKID != 0) begin : g_skid
    // in_ready comes straight from a flop, so no combinational path exists
    // from out_ready back to the upstream stage. Accepting while M is held
    // parks the entry in S, which then closes in_ready for the next cycle.
    assign in_ready = ~s_valid_q;

    always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_ctrl_d  = s_ctrl_q;
      s_data_d  = s_data_q;
      if (!m_valid_q || out_fire) begin
        // M is free this edge: the older entry in S goes first (FIFO order).
        if (s_valid_q) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = s_ctrl_q;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else if (in_fire) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = in_ctrl;
          m_data_d  = in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        s_valid_d = 1'b1;
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
      end
    end
  end else begin : g_single
    // Single register: can refill in the same edge it drains.
    assign in_ready = ~m_valid_q | out_ready;

    always_comb begin
      m_valid_d = m_valid_q;
      m_ctrl_d  = m_ctrl_q;
      m_data_d  = m_data_q;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
      s_data_d  = '0;
      if (!m_valid_q || out_ready) begin
        if (in_fire) begin
          m_valid_d = 1'b1;
          m_ctrl_d  = in_ctrl;
          m_data_d  = in_data;
        end else begin
          m_valid_d = 1'b0;
        end
      end
    end
  end

  // Priority: rst > flush > normal. Flush clears valid and control but keeps
  // the data bundles; the stall counter keeps counting through a flush.
  always_ff @(negedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        m_valid_q <= 1'b0;
        m_ctrl_q  <= '0;
        s_valid_q <= 1'b0;
        s_ctrl_q  <= '0;
      end else begin
        m_valid_q <= m_valid_d;
        m_ctrl_q  <= m_ctrl_d;
        m_data_q  <= m_data_d;
        s_valid_q <= s_valid_d;
        s_ctrl_q  <= s_ctrl_d;
        s_data_q  <= s_data_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_seg_reg.sv
// Testbench for pipe_seg_reg.
//   u_a : SKID=1, CNT_W=16   (main skid-buffer instance)
//   u_b : SKID=1, CNT_W=4    (same stimulus as u_a, exercises saturation)
//   u_c : SKID=0, CNT_W=16   (single-register variant, own stimulus)
// The reference model treats each segment as a bounded FIFO (depth 2 with
// skid, depth 1 without) plus a "last head data" register and a saturating
// counter. Inputs change one time unit after each falling edge; the compare
// process samples on the rising edge, half a cycle away from the updates.

module tb_pipe_seg_reg;

  localparam int DW = 16;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  // shared stimulus for u_a / u_b
  logic          in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [15:0]   a_stall;

  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [3:0]    b_stall;

  // stimulus for u_c
  logic          c_in_valid, c_out_ready;
  logic [CW-1:0] c_in_ctrl;
  logic [DW-1:0] c_in_data;

  logic          c_in_ready, c_out_valid;
  logic [CW-1:0] c_out_ctrl;
  logic [DW-1:0] c_out_data;
  logic [15:0]   c_stall;

  pipe_seg_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall)
  );

  pipe_seg_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall)
  );

  pipe_seg_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ctrl(c_in_ctrl), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
    .out_data(c_out_data), .stall_cnt(c_stall)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // ---------------- reference model ----------------
  // Entries are {ctrl, data}; the queue head is what the segment presents.
  logic [CW+DW-1:0] exp_q_a[$];
  logic [CW+DW-1:0] exp_q_c[$];
  logic [DW-1:0]    held_a, held_c;
  int unsigned      cnt_a, cnt_b, cnt_c;

  always @(negedge clk) begin
    bit ir, ov;
    // skid segment: holds up to two entries, ready while fewer than two held
    ir = (exp_q_a.size() < 2);
    ov = (exp_q_a.size() > 0);
    if (rst) begin
      exp_q_a.delete();
      held_a = '0;
      cnt_a  = 0;
      cnt_b  = 0;
    end else begin
      if (ov && !out_ready) begin
        cnt_a = sat_inc(cnt_a, 65535);
        cnt_b = sat_inc(cnt_b, 15);
      end
      if (flush) begin
        exp_q_a.delete();
      end else begin
        if (ov && out_ready) void'(exp_q_a.pop_front());
        if (in_valid && ir) exp_q_a.push_back({in_ctrl, in_data});
      end
      if (exp_q_a.size() > 0) held_a = exp_q_a[0][DW-1:0];
    end

    // single-register segment: one entry, ready when empty or draining
    ir = (exp_q_c.size() == 0) || c_out_ready;
    ov = (exp_q_c.size() > 0);
    if (rst) begin
      exp_q_c.delete();
      held_c = '0;
      cnt_c  = 0;
    end else begin
      if (ov && !c_out_ready) cnt_c = sat_inc(cnt_c, 65535);
      if (flush) begin
        exp_q_c.delete();
      end else begin
        if (ov && c_out_ready) void'(exp_q_c.pop_front());
        if (c_in_valid && ir) exp_q_c.push_back({c_in_ctrl, c_in_data});
      end
      if (exp_q_c.size() > 0) held_c = exp_q_c[0][DW-1:0];
    end
  end

  // ---------------- compare process ----------------
  logic [DW-1:0] seen_a[$];
  logic [DW-1:0] seen_c[$];

  always @(posedge clk) begin
    if (chk_en) begin
      logic [CW-1:0] ec;
      ec = (exp_q_a.size() > 0) ? exp_q_a[0][CW+DW-1:DW] : '0;
      check("a_out_valid", a_out_valid, exp_q_a.size() > 0);
      check("a_out_ctrl",  a_out_ctrl,  ec);
      check("a_out_data",  a_out_data,  held_a);
      check("a_in_ready",  a_in_ready,  exp_q_a.size() < 2);
      check("a_stall_cnt", a_stall,     cnt_a);
      check("b_out_valid", b_out_valid, exp_q_a.size() > 0);
      check("b_out_ctrl",  b_out_ctrl,  ec);
      check("b_out_data",  b_out_data,  held_a);
      check("b_in_ready",  b_in_ready,  exp_q_a.size() < 2);
      check("b_stall_cnt", b_stall,     cnt_b);

      ec = (exp_q_c.size() > 0) ? exp_q_c[0][CW+DW-1:DW] : '0;
      check("c_out_valid", c_out_valid, exp_q_c.size() > 0);
      check("c_out_ctrl",  c_out_ctrl,  ec);
      check("c_out_data",  c_out_data,  held_c);
      check("c_in_ready",  c_in_ready,  (exp_q_c.size() == 0) || c_out_ready);
      check("c_stall_cnt", c_stall,     cnt_c);

      // delivery log (inputs here are the ones the next falling edge samples)
      if (!rst && !flush && a_out_valid && out_ready) seen_a.push_back(a_out_data);
      if (!rst && !flush && c_out_valid && c_out_ready) seen_c.push_back(c_out_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_seen_a(input string name, input logic [DW-1:0] exp[$]);
    check({name, "_count"}, seen_a.size(), exp.size());
    foreach (exp[i]) check(name, (i < seen_a.size()) ? seen_a[i] : 'x, exp[i]);
    seen_a.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DW-1:0] exp_list[$];

    // Reset for two edges while an entry is being offered.
    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 16'h0077; out_ready = 1'b0;
    c_in_valid = 1'b1; c_in_ctrl = 8'hFF; c_in_data = 16'h0077; c_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_ctrl",  a_out_ctrl,  0);
    check("rst_out_data",  a_out_data,  0);
    check("rst_in_ready",  a_in_ready,  1);
    check("rst_stall_cnt", a_stall,     0);
    check("rst_c_in_ready", c_in_ready, 1);
    check("rst_c_out_data", c_out_data, 0);
    rst = 1'b0;
    in_valid = 1'b0; c_in_valid = 1'b0;

    // Streaming 1..8, ctrl 0x05, downstream always ready.
    out_ready = 1'b1; in_ctrl = 8'h05;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      tick();
      check("stream_latency", a_out_data, i);
    end
    in_valid = 1'b0;
    tick(2);
    exp_list = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    check_seen_a("stream_order", exp_list);
    check("stream_stall", a_stall, 0);

    // Backpressure: fill M and S, hold 0xC upstream.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 16'h000A; tick();
    in_data = 16'h000B; tick();
    in_data = 16'h000C; tick(2);
    check("bp_head",      a_out_data, 16'h000A);
    check("bp_out_valid", a_out_valid, 1);
    check("bp_in_ready",  a_in_ready, 0);
    check("bp_stall",     a_stall, 3);
    check("bp_stall_b",   b_stall, 3);
    out_ready = 1'b1;
    tick();
    check("bp_rel_head",  a_out_data, 16'h000B);
    check("bp_rel_ready", a_in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick(2);
    exp_list = '{16'h000A, 16'h000B, 16'h000C};
    check_seen_a("bp_order", exp_list);
    check("bp_stall_after", a_stall, 3);

    // Flush with both entries full and 0xD offered.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h81;
    in_data = 16'h0011; tick();
    in_data = 16'h0012; tick();
    flush = 1'b1; in_data = 16'h000D; tick();
    check("fl_out_valid", a_out_valid, 0);
    check("fl_out_ctrl",  a_out_ctrl, 0);
    check("fl_in_ready",  a_in_ready, 1);
    check("fl_data_held", a_out_data, 16'h0011);
    check("fl_stall",     a_stall, 5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(2);
    // Flush on an empty segment while an entry is accepted: it is dropped.
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h000E; tick();
    check("fl2_out_valid", a_out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    tick(2);
    exp_list.delete();
    check_seen_a("fl_nothing_out", exp_list);

    // Saturation: 20 stalled edges; 4-bit counter stops at 15.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h05; in_data = 16'h0021; tick();
    in_valid = 1'b0;
    tick(20);
    check("sat_b", b_stall, 15);
    check("sat_a", a_stall, 25);
    out_ready = 1'b1;
    tick(2);
    exp_list = '{16'h0021};
    check_seen_a("sat_order", exp_list);

    // SKID=0: M full, out_ready rises -> in_ready follows in the same cycle.
    c_out_ready = 1'b0; c_in_valid = 1'b1; c_in_ctrl = 8'h0A; c_in_data = 16'h0031;
    tick();
    c_in_data = 16'h0032;
    #1;
    check("c_full_in_ready", c_in_ready, 0);
    tick();
    c_out_ready = 1'b1;
    #1;
    check("c_comb_in_ready", c_in_ready, 1);
    tick();
    check("c_refill_data",  c_out_data, 16'h0032);
    check("c_refill_valid", c_out_valid, 1);
    check("c_refill_ctrl",  c_out_ctrl, 8'h0A);
    c_in_valid = 1'b0;
    tick(2);
    check("c_seen_count", seen_c.size(), 2);
    check("c_seen_0", (seen_c.size() > 0) ? seen_c[0] : 'x, 16'h0031);
    check("c_seen_1", (seen_c.size() > 1) ? seen_c[1] : 'x, 16'h0032);
    check("c_stall", c_stall, 1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_seg_reg.md
Name: pipe_seg_reg

Overview:
- Generic, parametrised pipeline segment register. It replaces the per-stage hand-written segment registers (IF/ID, ID/EX, EX/Mem, Mem/WB).
- Carries an opaque data bundle and a control bundle between two stages.
- Uses a valid/ready handshake, an optional 2-entry skid buffer, flush (bubble insertion) and a saturating stall counter.
- Stages instantiate it with their own concatenated field widths.

Parameters:
DATA_W, 128, width of data bundle (PC, rs/rt/rd, busA/busB, ALU/MULT results, ...)
CTRL_W, 8, width of control bundle (RegWr, MemWr, MemtoReg, RegDst, ...); forced to 0 whenever the stage holds a bubble
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock; all state updates on falling edge, matching pipeline segment convention
rst  in  1  synchronous active-high reset, sampled on falling edge of clk
flush  in  1  discard all held entries (branch/jump/exception squash)
in_valid  in  1  upstream stage presents an entry
in_ready  out  1  segment can accept an entry this cycle
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream stage consumes entry this cycle
out_ctrl  out  CTRL_W  control bundle; all zeros when out_valid=0
out_data  out  DATA_W  data bundle of head entry; held value when out_valid=0
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Storage: main entry M (valid, ctrl, data) drives outputs. Skid entry S exists only when SKID=1.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All sampled at the falling edge.
- in_ready, SKID=1: registered, equals !S.valid. No combinational path from out_ready.
- in_ready, SKID=0: equals !M.valid | out_ready (combinational).
- out_valid = M.valid.
- out_ctrl = M.valid ? M.ctrl : 0. A bubble can never assert RegWr/MemWr downstream.
- Priority at each falling edge: rst > flush > normal.
- rst: M.valid=S.valid=0; M.ctrl, M.data, S.* = 0; stall_cnt=0.
  - Resulting outputs: out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - Reset asserted mid-transfer drops all entries, including one being offered with in_valid=1.
- flush (rst=0):
  - M.valid=S.valid=0 and ctrl fields cleared; data fields hold.
  - An in_fire in the same cycle is discarded.
  - in_ready=1 on the next cycle.
  - stall_cnt is unaffected by flush itself, and still counts if the stall condition held that cycle.
- Normal, SKID=1:
  - If !M.valid or out_fire: M loads S when S.valid (then S.valid=0), else loads the input on in_fire, else M.valid=0.
  - Else (M held) and in_fire: S captures the input, so in_ready drops next cycle.
  - in_fire while S.valid is impossible, because in_ready=0.
  - Order is strictly FIFO: M drains before S, and S before new input.
- Normal, SKID=0:
  - If !M.valid or out_ready: M loads the input on in_fire, else M.valid=0.
  - Otherwise M holds.
- Latency and throughput: an entry accepted at edge n appears on the outputs after edge n (one segment). Sustained throughput is 1 entry/cycle when out_ready=1.
- stall_cnt: +1 on each edge with out_valid=1 & out_ready=0. Stays at 2^CNT_W-1 once reached (no wrap).
- Width rules: no arithmetic on the bundles. They pass bit-exact.

Test Plan:
- Reset: drive rst=1 for 2 edges with in_valid=1 and in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1; inject data 1..8 with ctrl=8'h05 on consecutive cycles -> out_data 1..8 on consecutive cycles, each one edge after acceptance, no gaps, stall_cnt=0.
- Backpressure (SKID=1): out_ready=0 while sending 0xA, 0xB, 0xC ->
  - M=0xA, S=0xB, in_ready=0, 0xC held upstream.
  - Release out_ready -> outputs 0xA, 0xB, 0xC in order.
  - stall_cnt equals the number of stalled edges.
- Flush with both entries full: flush=1 with in_valid=1 (data 0xD) -> next cycle out_valid=0, out_ctrl=0, in_ready=1. 0xD never appears at the output.
- Saturation: CNT_W=4, hold out_valid=1 & out_ready=0 for 20 edges -> stall_cnt stops at 15.
- SKID=0: M full and out_ready toggles 0→1 in the same cycle -> in_ready follows combinationally. New entry accepted that edge; no loss or duplication.
